// File: rtl/nphase_nonoverlap_gen.sv
// N-phase non-overlapping clock generator: round-robin phases with programmable high
// and dead times, shadowed configuration, and runt-free start/stop.
`timescale 1ns/1ps
module nphase_nonoverlap_gen #(
    parameter int NUM_PHASES = 2,
    parameter int CNT_W      = 8,
    parameter int RST_HIGH   = 1,
    parameter int RST_DEAD   = 1,
    localparam int IDX_W     = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  CLK_IN,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  CFG_LOAD,
    input  logic [CNT_W-1:0]      HIGH_CNT,
    input  logic [CNT_W-1:0]      DEAD_CNT,
    output logic [NUM_PHASES-1:0] PHI,
    output logic                  SYNC,
    output logic [IDX_W-1:0]      PHASE_IDX,
    output logic                  BUSY,
    output logic [1:0]            DBG_STATE
);

    // Handshake: none. EN is a level request sampled only at the end of each dead
    // gap (or every edge while idle); CFG_LOAD is a single-cycle capture strobe.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        sh_high_q, sh_high_d, sh_dead_q, sh_dead_d;
    logic [CNT_W-1:0]        act_high_q, act_high_d, act_dead_q, act_dead_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_PHASES-1:0]   phi_q, phi_d;
    logic                    sync_q, sync_d, busy_q, busy_d;

    // A zero count is promoted to one so no pulse or gap ever collapses.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sh_high_d  = sh_high_q;
        sh_dead_d  = sh_dead_q;
        act_high_d = act_high_q;
        act_dead_d = act_dead_q;

        if (CFG_LOAD) begin
            sh_high_d = HIGH_CNT;
            sh_dead_d = DEAD_CNT;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    state_d    = ST_HIGH;
                    idx_d      = '0;
                    act_high_d = sh_high_q;
                    act_dead_d = sh_dead_q;
                    cnt_d      = at_least_one(sh_high_q);
                end
            end
            ST_HIGH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DEAD;
                    cnt_d   = at_least_one(act_dead_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DEAD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    if (!EN) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        // Sequence boundary: the only point where new config takes effect.
                        state_d    = ST_HIGH;
                        idx_d      = '0;
                        act_high_d = sh_high_q;
                        act_dead_d = sh_dead_q;
                        cnt_d      = at_least_one(sh_high_q);
                    end else begin
                        state_d = ST_HIGH;
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = at_least_one(act_high_q);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        phi_d  = (state_d == ST_HIGH) ? (NUM_PHASES'(1) << idx_d) : '0;
        sync_d = (state_d == ST_HIGH) && (state_q != ST_HIGH) && (idx_d == '0);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_high_q  <= CNT_W'(RST_HIGH);
            sh_dead_q  <= CNT_W'(RST_DEAD);
            act_high_q <= CNT_W'(RST_HIGH);
            act_dead_q <= CNT_W'(RST_DEAD);
            phi_q      <= '0;
            sync_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_high_q  <= sh_high_d;
            sh_dead_q  <= sh_dead_d;
            act_high_q <= act_high_d;
            act_dead_q <= act_dead_d;
            phi_q      <= phi_d;
            sync_q     <= sync_d;
            busy_q     <= busy_d;
        end
    end

    assign PHI       = phi_q;
    assign SYNC      = sync_q;
    assign PHASE_IDX = idx_q;
    assign BUSY      = busy_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_nphase_nonoverlap_gen.sv
// Self-checking bench for nphase_nonoverlap_gen: a 2-phase/8-bit and a 4-phase/4-bit
// instance driven against an arithmetic waveform model.
`timescale 1ns/1ps
module tb_nphase_nonoverlap_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1: N=2, CNT_W=8 ----------------
    logic       en1 = 1'b0, load1 = 1'b0;
    logic [7:0] hi1 = '0, dd1 = '0;
    logic [1:0] phi1;
    logic       sync1, busy1;
    logic [0:0] idx1;
    logic [1:0] st1;

    nphase_nonoverlap_gen #(.NUM_PHASES(2), .CNT_W(8), .RST_HIGH(1), .RST_DEAD(1)) dut1 (
        .CLK_IN(clk), .RST_N(rst_n), .EN(en1), .CFG_LOAD(load1),
        .HIGH_CNT(hi1), .DEAD_CNT(dd1), .PHI(phi1), .SYNC(sync1),
        .PHASE_IDX(idx1), .BUSY(busy1), .DBG_STATE(st1)
    );

    // ---------------- DUT 2: N=4, CNT_W=4 ----------------
    logic       en2 = 1'b0, load2 = 1'b0;
    logic [3:0] hi2 = '0, dd2 = '0;
    logic [3:0] phi2;
    logic       sync2, busy2;
    logic [1:0] idx2;
    logic [1:0] st2;

    nphase_nonoverlap_gen #(.NUM_PHASES(4), .CNT_W(4), .RST_HIGH(1), .RST_DEAD(1)) dut2 (
        .CLK_IN(clk), .RST_N(rst_n), .EN(en2), .CFG_LOAD(load2),
        .HIGH_CNT(hi2), .DEAD_CNT(dd2), .PHI(phi2), .SYNC(sync2),
        .PHASE_IDX(idx2), .BUSY(busy2), .DBG_STATE(st2)
    );

    int checks = 0;
    int errors = 0;

    // Expected per-cycle word: {busy, sync, idx[1:0], phi[3:0]}
    logic [7:0] exp_q[$];

    function automatic logic [7:0] observe(input int sel);
        if (sel == 0) return {busy1, sync1, 1'b0, idx1, 2'b00, phi1};
        return {busy2, sync2, idx2, phi2};
    endfunction

    // ---------------- non-overlap monitor ----------------
    logic [1:0] prev1 = '0;
    logic [3:0] prev2 = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(phi1) > 1 || (phi1 != 0 && prev1 != 0 && phi1 != prev1)) begin
                errors++;
                $display("FAIL nonoverlap1 t=%0t phi=%b prev=%b required one-hot-or-zero with gap", $time, phi1, prev1);
            end
            checks++;
            if ($countones(phi2) > 1 || (phi2 != 0 && prev2 != 0 && phi2 != prev2)) begin
                errors++;
                $display("FAIL nonoverlap2 t=%0t phi=%b prev=%b required one-hot-or-zero with gap", $time, phi2, prev2);
            end
            prev1 = phi1;
            prev2 = phi2;
        end
    end

    // ---------------- reference model ----------------
    // Cycle k (1-based) is the value seen after edge t0+k, t0 being the edge that
    // samples EN=1 in IDLE. Sequence 0 uses config A, later sequences config B.
    // EN is low at every edge after t0+stop_edge; a phase whose last dead cycle
    // ends at edge t0+k stops the run when k > stop_edge.
    task automatic build_expect(input int n, input int h_a, input int d_a,
                                input int h_b, input int d_b, input int stop_edge);
        int  k, h, d, last;
        bit  done;
        exp_q.delete();
        k = 0; done = 0; last = 0;
        for (int s = 0; !done; s++) begin
            h = (s == 0) ? h_a : h_b;
            d = (s == 0) ? d_a : d_b;
            if (h < 1) h = 1;
            if (d < 1) d = 1;
            for (int p = 0; p < n && !done; p++) begin
                for (int c = 0; c < h; c++) begin
                    exp_q.push_back({1'b1, 1'((c == 0) && (p == 0)), 2'(p), 4'(1 << p)});
                    k++;
                end
                for (int c = 0; c < d; c++) begin
                    exp_q.push_back({1'b1, 1'b0, 2'(p), 4'b0000});
                    k++;
                end
                if (k > stop_edge) begin
                    done = 1;
                    last = p;
                end
            end
        end
        repeat (3) exp_q.push_back({1'b0, 1'b0, 2'(last), 4'b0000});
    endtask

    // ---------------- drivers ----------------
    task automatic drive_en(input int sel, input logic v);
        if (sel == 0) en1 = v; else en2 = v;
    endtask

    task automatic drive_load(input int sel, input logic v, input int h, input int d);
        if (sel == 0) begin load1 = v; hi1 = 8'(h); dd1 = 8'(d); end
        else          begin load2 = v; hi2 = 4'(h); dd2 = 4'(d); end
    endtask

    task automatic load_cfg(input int sel, input int h, input int d);
        @(posedge clk); #1;
        drive_load(sel, 1'b1, h, d);
        @(posedge clk); #1;
        drive_load(sel, 1'b0, h, d);
    endtask

    // Starts a run from IDLE and compares every cycle of exp_q.
    task automatic run_scenario(input int sel, input string name, input int stop_edge,
                                input int load_edge, input int new_h, input int new_d);
        int         len;
        logic [7:0] obs;
        len = exp_q.size();
        @(posedge clk); #1;
        drive_en(sel, 1'b1);
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            if (k - 1 == stop_edge) drive_en(sel, 1'b0);
            drive_load(sel, (k - 1 == load_edge), new_h, new_d);
            @(negedge clk);
            obs = observe(sel);
            checks++;
            if (obs !== exp_q[k-1]) begin
                errors++;
                $display("FAIL %s cycle=%0d got {busy,sync,idx,phi}=%h required=%h", name, k, obs, exp_q[k-1]);
            end
        end
        drive_load(sel, 1'b0, new_h, new_d);
        drive_en(sel, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (observe(0) !== 8'h00) begin
            errors++;
            $display("FAIL reset_dut1 got=%h required=00", observe(0));
        end
        checks++;
        if (observe(1) !== 8'h00) begin
            errors++;
            $display("FAIL reset_dut2 got=%h required=00", observe(1));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        load_cfg(0, 3, 1);
        build_expect(2, 3, 1, 3, 1, 8);
        run_scenario(0, "basic_h3d1", 8, -1, 0, 0);
    endtask

    task automatic test_stop_mid_high();
        load_cfg(0, 3, 1);
        build_expect(2, 3, 1, 3, 1, 5);
        run_scenario(0, "stop_mid_high", 5, -1, 0, 0);
    endtask

    task automatic test_cfg_midseq();
        load_cfg(0, 3, 1);
        build_expect(2, 3, 1, 5, 1, 20);
        run_scenario(0, "cfg_midseq", 20, 5, 5, 1);
    endtask

    task automatic test_zero_counts();
        load_cfg(0, 0, 0);
        build_expect(2, 0, 0, 0, 0, 9);
        run_scenario(0, "zero_counts", 9, -1, 0, 0);
    endtask

    task automatic test_random();
        int h, d, h2, d2, per, le, se;
        for (int i = 0; i < 8; i++) begin
            h  = $urandom_range(0, 6);
            d  = $urandom_range(0, 4);
            h2 = $urandom_range(0, 6);
            d2 = $urandom_range(0, 4);
            per = 2 * ((h < 1 ? 1 : h) + (d < 1 ? 1 : d));
            le  = $urandom_range(0, per - 2);
            se  = $urandom_range(0, 3 * per);
            load_cfg(0, h, d);
            build_expect(2, h, d, h2, d2, se);
            run_scenario(0, $sformatf("random%0d_h%0d_d%0d", i, h, d), se, le, h2, d2);
        end
    endtask

    task automatic test_max_count();
        load_cfg(0, 255, 0);
        build_expect(2, 255, 0, 255, 0, 0);
        run_scenario(0, "max_count_255", 0, -1, 0, 0);
    endtask

    task automatic test_async_reset();
        load_cfg(0, 4, 2);
        @(posedge clk); #1;
        en1 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (phi1 !== 2'b00 || busy1 !== 1'b0 || sync1 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset phi=%b busy=%b sync=%b required phi=00 busy=0 sync=0", phi1, busy1, sync1);
        end
        en1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        build_expect(2, 1, 1, 1, 1, 5);
        run_scenario(0, "restart_after_reset", 5, -1, 0, 0);
    endtask

    task automatic test_four_phase();
        load_cfg(1, 15, 2);
        build_expect(4, 15, 2, 15, 2, 70);
        run_scenario(1, "four_phase_h15d2", 70, -1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stop_mid_high();
        test_cfg_midseq();
        test_zero_counts();
        test_random();
        test_max_count();
        test_async_reset();
        test_four_phase();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
